// File: rtl/game_sequencer.sv
// game_sequencer: phase controller for the VGA snake game.
// Debounces buttons, sequences title/countdown/play/pause/over, tracks high score.
module game_sequencer #(
    parameter int DEBOUNCE_FRAMES  = 2,
    parameter int COUNT_FRAMES     = 60,
    parameter int OVER_HOLD_FRAMES = 120,
    parameter int SCORE_BITS       = 8
) (
    input  logic                  clock_25,
    input  logic                  reset,
    input  logic                  frame_tik,
    input  logic                  game_tik,
    input  logic                  right_P,
    input  logic                  left_P,
    input  logic                  collision,
    input  logic [SCORE_BITS-1:0] score,
    output logic [2:0]            phase,
    output logic                  game_enable,
    output logic                  new_game,
    output logic                  game_tik_run,
    output logic                  right_cmd,
    output logic                  left_cmd,
    output logic [1:0]            countdown,
    output logic [SCORE_BITS-1:0] high_score
);

    localparam logic [2:0] TITLE     = 3'd0;
    localparam logic [2:0] COUNTDOWN = 3'd1;
    localparam logic [2:0] PLAY      = 3'd2;
    localparam logic [2:0] PAUSE     = 3'd3;
    localparam logic [2:0] OVER      = 3'd4;

    localparam int DW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam int CW = $clog2(COUNT_FRAMES + 1);
    localparam int HW = $clog2(OVER_HOLD_FRAMES + 1);

    localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_FRAMES - 1);
    localparam logic [CW-1:0] CMAX = CW'(COUNT_FRAMES - 1);
    localparam logic [HW-1:0] HMAX = HW'(OVER_HOLD_FRAMES);

    // index 0 = right, index 1 = left
    logic [1:0]    raw;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    db;
    logic [1:0]    db_q;
    logic [DW-1:0] dcnt [2];
    logic [1:0]    press;
    logic          any_press;

    logic [2:0]    state;
    logic [CW-1:0] fcnt;
    logic [HW-1:0] hcnt;
    logic          released;

    assign raw       = {left_P, right_P};
    assign press     = db & ~db_q;
    assign any_press = |press;
    assign phase     = state;

    // Synchronize and debounce both buttons on frame_tik samples
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            db    <= '0;
            db_q  <= '0;
            for (int i = 0; i < 2; i++) dcnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            db_q  <= db;
            if (frame_tik) begin
                for (int i = 0; i < 2; i++) begin
                    if (sync2[i] != db[i]) begin
                        if (dcnt[i] == DMAX) begin
                            db[i]   <= ~db[i];
                            dcnt[i] <= '0;
                        end else begin
                            dcnt[i] <= dcnt[i] + 1'b1;
                        end
                    end else begin
                        dcnt[i] <= '0;
                    end
                end
            end
        end
    end

    // Phase sequencing, gated commands and high score tracking
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            state        <= TITLE;
            game_enable  <= 1'b0;
            new_game     <= 1'b0;
            game_tik_run <= 1'b0;
            right_cmd    <= 1'b0;
            left_cmd     <= 1'b0;
            countdown    <= 2'd0;
            high_score   <= '0;
            fcnt         <= '0;
            hcnt         <= '0;
            released     <= 1'b0;
        end else begin
            new_game     <= 1'b0;
            right_cmd    <= 1'b0;
            left_cmd     <= 1'b0;
            game_tik_run <= game_tik && (state == PLAY);
            case (state)
                TITLE: begin
                    if (any_press) begin
                        state       <= COUNTDOWN;
                        game_enable <= 1'b1;
                        new_game    <= 1'b1;
                        countdown   <= 2'd3;
                        fcnt        <= '0;
                    end
                end
                COUNTDOWN: begin
                    if (frame_tik) begin
                        if (fcnt == CMAX) begin
                            fcnt <= '0;
                            if (countdown <= 2'd1) begin
                                state     <= PLAY;
                                countdown <= 2'd0;
                            end else begin
                                countdown <= countdown - 2'd1;
                            end
                        end else begin
                            fcnt <= fcnt + 1'b1;
                        end
                    end
                end
                PLAY: begin
                    if (collision) begin
                        state       <= OVER;
                        game_enable <= 1'b0;
                        hcnt        <= '0;
                        if (score > high_score) high_score <= score;
                    end else if (frame_tik && (&db)) begin
                        state    <= PAUSE;
                        released <= 1'b0;
                    end else begin
                        right_cmd <= press[0];
                        left_cmd  <= press[1];
                    end
                end
                PAUSE: begin
                    if (released && any_press) begin
                        state <= PLAY;
                    end else if (~|db) begin
                        released <= 1'b1;
                    end
                end
                OVER: begin
                    if (frame_tik && (hcnt != HMAX)) hcnt <= hcnt + 1'b1;
                    if ((hcnt == HMAX) && any_press) state <= TITLE;
                end
                default: begin
                    state       <= TITLE;
                    game_enable <= 1'b0;
                    countdown   <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed scoreboard bench for game_sequencer.
// Expectations are queued with the stimulus and popped when outputs are sampled.
module tb_game_sequencer;

    localparam int FP = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       frame_tik = 1'b0;
    logic       game_tik = 1'b0;
    logic       right_P = 1'b0;
    logic       left_P = 1'b0;
    logic       collision = 1'b0;
    logic [7:0] score = 8'd0;
    logic [2:0] phase;
    logic       game_enable;
    logic       new_game;
    logic       game_tik_run;
    logic       right_cmd;
    logic       left_cmd;
    logic [1:0] countdown;
    logic [7:0] high_score;

    int errors = 0;
    int checks = 0;
    string       tq[$];
    logic [31:0] eq[$];
    int n_new = 0, n_r = 0, n_l = 0, n_gt = 0;
    int s0, c2, c1;

    game_sequencer dut (
        .clock_25(clk), .reset(reset), .frame_tik(frame_tik),
        .game_tik(game_tik), .right_P(right_P), .left_P(left_P),
        .collision(collision), .score(score), .phase(phase),
        .game_enable(game_enable), .new_game(new_game),
        .game_tik_run(game_tik_run), .right_cmd(right_cmd),
        .left_cmd(left_cmd), .countdown(countdown),
        .high_score(high_score)
    );

    always #5 clk = ~clk;

    // Pulse counters for the one-cycle outputs
    always @(posedge clk) begin
        if (new_game) n_new <= n_new + 1;
        if (right_cmd) n_r <= n_r + 1;
        if (left_cmd) n_l <= n_l + 1;
        if (game_tik_run) n_gt <= n_gt + 1;
    end

    // One frame_tik every FP cycles
    initial begin
        forever begin
            repeat (FP - 1) @(negedge clk);
            frame_tik = 1'b1;
            @(negedge clk);
            frame_tik = 1'b0;
        end
    end

    task automatic push(input string t, input logic [31:0] v);
        tq.push_back(t);
        eq.push_back(v);
    endtask

    task automatic chk(input logic [31:0] obs);
        string t;
        logic [31:0] e;
        t = tq.pop_front();
        e = eq.pop_front();
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", t, obs, e);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frames(input int n);
        cyc(n * FP);
    endtask

    task automatic hold(input logic r, input logic l, input int nf);
        right_P = r;
        left_P = l;
        frames(nf);
        right_P = 1'b0;
        left_P = 1'b0;
    endtask

    task automatic wait_phase(input logic [2:0] p, input int budget,
                              output int d2, output int d1);
        d2 = 0;
        d1 = 0;
        push("phase_reached", 32'(p));
        for (int i = 0; i < budget && phase !== p; i++) begin
            @(negedge clk);
            if (countdown == 2'd2) d2++;
            if (countdown == 2'd1) d1++;
        end
        chk(32'(phase));
    endtask

    initial begin
        // reset state
        push("rst_phase", 0); push("rst_en", 0); push("rst_hs", 0);
        push("rst_new", 0); push("rst_rc", 0); push("rst_lc", 0);
        push("rst_gt", 0); push("rst_cd", 0);
        cyc(3);
        chk(32'(phase)); chk(32'(game_enable)); chk(32'(high_score));
        chk(32'(new_game)); chk(32'(right_cmd)); chk(32'(left_cmd));
        chk(32'(game_tik_run)); chk(32'(countdown));
        reset = 1'b1;

        // idle title, game_tik blocked
        push("title_idle", 0);
        frames(10);
        chk(32'(phase));
        push("title_gt", 0);
        game_tik = 1'b1; cyc(1); game_tik = 1'b0;
        chk(32'(game_tik_run));

        // start: countdown 3,2,1
        s0 = n_new;
        push("cd_phase", 1); push("cd_digit", 3); push("new_pulses", 1);
        hold(1'b1, 1'b0, 3);
        chk(32'(phase)); chk(32'(countdown)); chk(32'(n_new - s0));
        wait_phase(3'd2, 4000, c2, c1);
        push("digit2_cycles", 60 * FP); push("digit1_cycles", 60 * FP);
        push("play_en", 1); push("play_cd", 0);
        chk(32'(c2)); chk(32'(c1));
        chk(32'(game_enable)); chk(32'(countdown));

        // left press gives one left_cmd
        s0 = n_l; c2 = n_r;
        push("left_pulses", 1); push("right_none", 0);
        hold(1'b0, 1'b1, 4);
        frames(4);
        chk(32'(n_l - s0)); chk(32'(n_r - c2));

        // game_tik passes one cycle later
        s0 = n_gt;
        push("gt_run", 1); push("gt_after", 0); push("gt_count", 1);
        game_tik = 1'b1; cyc(1); game_tik = 1'b0;
        chk(32'(game_tik_run));
        cyc(1);
        chk(32'(game_tik_run)); chk(32'(n_gt - s0));

        // one-frame glitch is filtered
        s0 = n_r;
        push("glitch_cmd", 0); push("glitch_phase", 2);
        do @(posedge clk); while (!frame_tik);
        @(negedge clk);
        right_P = 1'b1; cyc(FP); right_P = 1'b0;
        frames(4);
        chk(32'(n_r - s0)); chk(32'(phase));

        // both held: pause, game_tik blocked
        push("pause_phase", 3); push("pause_gt", 0); push("pause_hold", 3);
        right_P = 1'b1; left_P = 1'b1;
        frames(4);
        chk(32'(phase));
        game_tik = 1'b1; cyc(1); game_tik = 1'b0;
        chk(32'(game_tik_run));
        right_P = 1'b0; left_P = 1'b0;
        frames(4);
        chk(32'(phase));

        // resume without command
        s0 = n_r;
        push("resume_phase", 2); push("resume_cmd", 0);
        hold(1'b1, 1'b0, 3);
        frames(2);
        chk(32'(phase)); chk(32'(n_r - s0));

        // collision with score 25
        push("over_phase", 4); push("over_en", 0); push("over_hs", 25);
        score = 8'd25;
        collision = 1'b1; cyc(1); collision = 1'b0;
        cyc(2);
        chk(32'(phase)); chk(32'(game_enable)); chk(32'(high_score));

        // press during hold is ignored, after hold returns to title
        push("hold_ignore", 4); push("hold_done", 0);
        frames(50);
        hold(1'b1, 1'b0, 3);
        frames(7);
        chk(32'(phase));
        frames(70);
        hold(1'b1, 1'b0, 3);
        frames(1);
        chk(32'(phase));

        // second game ends lower: high score kept
        frames(4);
        hold(1'b1, 1'b0, 3);
        wait_phase(3'd2, 4000, c2, c1);
        push("g2_phase", 4); push("g2_hs", 25);
        score = 8'd10;
        collision = 1'b1; cyc(1); collision = 1'b0;
        cyc(2);
        chk(32'(phase)); chk(32'(high_score));

        // async reset clears everything
        push("mid_rst_hs", 0); push("mid_rst_phase", 0); push("mid_rst_en", 0);
        reset = 1'b0;
        #1;
        chk(32'(high_score)); chk(32'(phase)); chk(32'(game_enable));
        cyc(2);
        reset = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Top-level game phase controller for the VGA snake design. It sits between the push-buttons, `game_delay`, `snake_game_fsm` and `graphic_game`. It debounces the buttons and sequences the game through title, countdown, play, pause and game-over phases. It gates the game tick and direction commands into the snake FSM, and tracks the high score.

## Interface
Parameters:
- `DEBOUNCE_FRAMES`, default 2: consecutive frame_tik samples a button must be stable before its debounced level changes.
- `COUNT_FRAMES`, default 60: frame_tiks per countdown digit.
- `OVER_HOLD_FRAMES`, default 120: frame_tiks during which buttons are ignored after game over.
- `SCORE_BITS`, default 8: width of the score and high_score buses.

Ports:
- `clock_25` in 1: 25 MHz system clock.
- `reset` in 1: asynchronous, active-low reset.
- `frame_tik` in 1: one-cycle pulse per video frame.
- `game_tik` in 1: one-cycle pulse per game step, from `game_delay`.
- `right_P`, `left_P` in 1 each: raw button levels, active-high, asynchronous.
- `collision` in 1: level from the snake FSM, high while the head overlaps a wall or the body.
- `score` in SCORE_BITS: current score.
- `phase` out 3: current state encoding; TITLE=0, COUNTDOWN=1, PLAY=2, PAUSE=3, OVER=4.
- `game_enable` out 1: high in COUNTDOWN, PLAY and PAUSE; low in TITLE and OVER, where the background ROM is shown.
- `new_game` out 1: one-cycle pulse that clears the snake FSM.
- `game_tik_run` out 1: game_tik gated to PLAY.
- `right_cmd`, `left_cmd` out 1 each: one-cycle turn commands.
- `countdown` out 2: digit currently displayed, 3..1; 0 outside COUNTDOWN.
- `high_score` out SCORE_BITS: highest score reached since reset.

## Operation
Button conditioning:
- Each button passes through a 2-flop synchronizer on `clock_25`.
- A per-button counter samples the synchronized value on each frame_tik.
- The debounced level flips once the sample has differed from it for DEBOUNCE_FRAMES consecutive frame_tiks. Any agreeing sample clears the counter.
- A press edge is a one-cycle pulse in the cycle after the debounced level rises.

State machine:
- Reset → TITLE.
- TITLE: any press edge → COUNTDOWN. `new_game` is asserted in the first COUNTDOWN cycle. The countdown digit loads 3 and the frame counter loads 0.
- COUNTDOWN: the frame counter increments on each frame_tik. When it reaches COUNT_FRAMES-1 on a frame_tik, the counter clears and the digit decrements. If the digit is 1 at that point, the state goes to PLAY instead. Buttons are ignored.
- PLAY, evaluated in priority order:
  - `collision` high → OVER.
  - Both debounced levels high on a frame_tik → PAUSE.
  - Otherwise each press edge drives `right_cmd`/`left_cmd` for one cycle.
- PAUSE: a `released` flag is set once both debounced levels are low. After that, any press edge → PLAY. That edge produces no command.
- OVER:
  - On the entry cycle, `high_score` loads `score` if score > high_score (unsigned compare).
  - The hold counter counts OVER_HOLD_FRAMES frame_tiks.
  - After the hold, any press edge → TITLE.
  - Press edges during the hold are discarded, not queued.

## Timing
- All outputs are registered. Every output is 0 while `reset` is low, including `high_score` and `phase` (TITLE).
- `game_tik_run` is game_tik delayed one cycle, qualified by phase==PLAY in the same cycle as game_tik.
- A command appears one cycle after its press edge, and only if phase==PLAY in that edge cycle.
- Button change to command: 2 sync cycles plus DEBOUNCE_FRAMES frame_tiks plus 1 cycle.
- frame_tik and game_tik coincident: both are honored independently.
- collision coincident with the pause condition: OVER wins and no command is issued.
- Reset asserted mid-game: immediate return to TITLE. The high score is cleared.
- Counters saturate and never wrap. The countdown digit never goes below 1 while in COUNTDOWN.

## Test plan
- Reset low → phase=0, game_enable=0, high_score=0, all pulses 0. Release reset and hold the buttons idle for 10 frames → phase stays 0.
- right_P held for 3 frames from TITLE → one `new_game` pulse, phase=1, countdown shows 3, 2, 1 for 60 frames each, then phase=2 with game_enable=1.
- In PLAY, press left_P → exactly one `left_cmd` pulse. game_tik pulses appear on `game_tik_run` one cycle later. A 1-frame glitch on right_P → no command.
- In PLAY, hold both buttons → phase=3 and `game_tik_run` stays 0. Release both, then press right → phase=2 with no `right_cmd`.
- Collision in PLAY with score=25 → phase=4, game_enable=0, high_score=25. A later game ending with score=10 leaves high_score=25.
- In OVER, press at frame 50 → ignored. Press after frame 120 → phase=0.
